// File: rtl/interp_10x.sv
// interp_10x: fixed 10x linear interpolator stage.
// A clk_en strobe captures a sample pair (x0 older, x1 newer). Each following
// clk_en_10x step then writes one more of the ten evenly spaced points
// y_k = x0 + floor((k*delta + r) / 10), with delta = x1 - x0.
// Optional build macro INTERP_ROUND_EN: when defined r = 5 (round half up),
// otherwise r = 0 (pure floor). Timing and handshake are the same in both builds.
module interp_10x #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clk_en_10x,
  input  logic [WIDTH-1:0] sample_x0,
  input  logic [WIDTH-1:0] sample_x1,
  output logic             end_stage,
  output logic [WIDTH-1:0] sample_y0,
  output logic [WIDTH-1:0] sample_y1,
  output logic [WIDTH-1:0] sample_y2,
  output logic [WIDTH-1:0] sample_y3,
  output logic [WIDTH-1:0] sample_y4,
  output logic [WIDTH-1:0] sample_y5,
  output logic [WIDTH-1:0] sample_y6,
  output logic [WIDTH-1:0] sample_y7,
  output logic [WIDTH-1:0] sample_y8,
  output logic [WIDTH-1:0] sample_y9
);

  // Datapath width: |k*delta| < 10*2^WIDTH, and after biasing the numerator
  // stays below 20*2^WIDTH, so WIDTH+6 bits hold everything as a positive value.
  localparam int PW = WIDTH + 6;

  // Adding 10*2^WIDTH makes the numerator non-negative, so a plain unsigned
  // divide by 10 gives the mathematical floor; the quotient then carries an
  // extra 2^WIDTH which is removed again when adding x0.
  localparam logic [PW-1:0] OFFSET = PW'(10) << WIDTH;
  localparam logic [PW-1:0] QBIAS  = PW'(1) << WIDTH;
`ifdef INTERP_ROUND_EN
  localparam logic [PW-1:0] ROUND  = PW'(5);
`else
  localparam logic [PW-1:0] ROUND  = PW'(0);
`endif

  // x1 is not kept separately: together with x0 it is fully described by delta.
  logic [WIDTH-1:0]        x0_q, x0_d;
  logic signed [WIDTH:0]   delta_q, delta_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    end_q, end_d;
  logic [WIDTH-1:0]        y_q [10];
  logic [WIDTH-1:0]        y_d [10];

  logic signed [PW-1:0]    kExt;
  logic signed [PW-1:0]    deltaExt;
  logic signed [PW-1:0]    prod;
  logic [PW-1:0]           biased;
  logic [PW-1:0]           quot;
  logic [WIDTH-1:0]        yStep;

  assign kExt     = {{(PW-4){1'b0}}, cnt_q};
  assign deltaExt = {{(PW-WIDTH-1){delta_q[WIDTH]}}, delta_q};

  // Point for the current step: exact floor division of the biased numerator.
  always_comb begin
    prod   = kExt * deltaExt;
    biased = $unsigned(prod) + ROUND + OFFSET;
    quot   = biased / PW'(10);
    yStep  = WIDTH'({{(PW-WIDTH){1'b0}}, x0_q} + quot - QBIAS);
  end

  // Block control: clk_en (re)starts a block and wins over a coincident step;
  // steps while busy fill y1..y9, and the y9 step raises end_stage for one cycle.
  always_comb begin
    x0_d    = x0_q;
    delta_d = delta_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    end_d   = 1'b0;
    y_d     = y_q;
    if (clk_en) begin
      x0_d    = sample_x0;
      delta_d = $signed({1'b0, sample_x1}) - $signed({1'b0, sample_x0});
      y_d[0]  = sample_x0;
      cnt_d   = 4'd1;
      busy_d  = 1'b1;
    end else if (clk_en_10x && busy_q) begin
      for (int i = 1; i < 10; i++) begin
        if (cnt_q == 4'(i)) begin
          y_d[i] = yStep;
        end
      end
      if (cnt_q == 4'd9) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
        end_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x0_q    <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      x0_q    <= x0_d;
      delta_q <= delta_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      y_q     <= y_d;
    end
  end

  assign end_stage = end_q;
  assign sample_y0 = y_q[0];
  assign sample_y1 = y_q[1];
  assign sample_y2 = y_q[2];
  assign sample_y3 = y_q[3];
  assign sample_y4 = y_q[4];
  assign sample_y5 = y_q[5];
  assign sample_y6 = y_q[6];
  assign sample_y7 = y_q[7];
  assign sample_y8 = y_q[8];
  assign sample_y9 = y_q[9];

endmodule

// File: tb/tb_interp_10x.sv
// tb_interp_10x: scoreboard bench for interp_10x.
// Blocks are issued with random samples, step spacing and aborts; the expected
// ten points of every block that should complete are queued together with the
// cycle on which end_stage must appear, and a monitor pops them on end_stage.
module tb_interp_10x;

  localparam int WIDTH = 8;
`ifdef INTERP_ROUND_EN
  localparam int ROUNDC = 5;
`else
  localparam int ROUNDC = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             clk_en_10x;
  logic [WIDTH-1:0] sample_x0;
  logic [WIDTH-1:0] sample_x1;
  logic             end_stage;
  logic [WIDTH-1:0] yOut [10];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int expY[$];
  int expEnd[$];
  int shadow[10];

  interp_10x #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clk_en_10x(clk_en_10x),
    .sample_x0(sample_x0), .sample_x1(sample_x1), .end_stage(end_stage),
    .sample_y0(yOut[0]), .sample_y1(yOut[1]), .sample_y2(yOut[2]),
    .sample_y3(yOut[3]), .sample_y4(yOut[4]), .sample_y5(yOut[5]),
    .sample_y6(yOut[6]), .sample_y7(yOut[7]), .sample_y8(yOut[8]),
    .sample_y9(yOut[9])
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count rising edges so end_stage timing can be checked against a cycle number.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: y_k = x0 + floor((k*(x1-x0) + r) / 10) using integer arithmetic.
  function automatic int modelY(input int x0, input int x1, input int k);
    int num;
    int q;
    num = k * (x1 - x0) + ROUNDC;
    q = num / 10;
    if (num < 0 && (num % 10) != 0) q = q - 1;
    return x0 + q;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare every output against the bench's picture of what was last written.
  task automatic checkAll(input string tag);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("%s_y%0d", tag, k), int'(yOut[k]), shadow[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one block: clk_en, then 9 steps spaced gap cycles apart; abortAt>0
  // stops after that many steps so the next block restarts it.
  task automatic applyStimulus(input int x0, input int x1, input int gap,
                               input int abortAt, input bit coincide);
    int start;
    sample_x0  = WIDTH'(x0);
    sample_x1  = WIDTH'(x1);
    clk_en     = 1'b1;
    clk_en_10x = coincide;
    tick();
    clk_en = 1'b0;
    start = cyc;
    shadow[0] = x0;
    checkAll($sformatf("start%0d_%0d", x0, x1));
    if (abortAt == 0) begin
      expEnd.push_back(start + 9 * gap);
      for (int k = 0; k < 10; k++) expY.push_back(modelY(x0, x1, k));
    end
    for (int s = 1; s < 10; s++) begin
      if (abortAt != 0 && s > abortAt) return;
      for (int g = 0; g < gap - 1; g++) begin
        clk_en_10x = 1'b0;
        tick();
      end
      clk_en_10x = 1'b1;
      tick();
      shadow[s] = modelY(x0, x1, s);
    end
    clk_en_10x = 1'($urandom_range(0, 1));
  endtask

  // Monitor: every end_stage pulse must match the oldest expected block.
  always @(negedge clk) begin
    int e;
    if (end_stage === 1'b1) begin
      if (expEnd.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_end_stage: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = expEnd.pop_front();
        checkOutput("end_cycle", cyc, e);
        for (int k = 0; k < 10; k++) begin
          checkOutput($sformatf("blk_y%0d", k), int'(yOut[k]), expY.pop_front());
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int k = 0; k < 10; k++) shadow[k] = 0;
    reset      = 1'b0;
    clk_en     = 1'b1;
    clk_en_10x = 1'b1;
    sample_x0  = 8'd77;
    sample_x1  = 8'd200;

    // Reset held with active strobes: everything stays cleared.
    repeat (3) begin
      tick();
      checkAll("reset");
      checkOutput("reset_end", int'(end_stage), 0);
    end

    // Released, idle, steps ignored while not busy.
    reset  = 1'b1;
    clk_en = 1'b0;
    repeat (5) tick();
    checkAll("idle");
    checkOutput("idle_end", int'(end_stage), 0);

    // Directed slopes with steps tied high.
    applyStimulus(0, 100, 1, 0, 1'b1);
    applyStimulus(200, 100, 1, 0, 1'b1);
    applyStimulus(0, 7, 1, 0, 1'b1);
    applyStimulus(10, 3, 1, 0, 1'b1);
    applyStimulus(0, 255, 1, 0, 1'b1);
    applyStimulus(255, 0, 1, 0, 1'b1);
    applyStimulus(42, 42, 1, 0, 1'b1);

    // Slow steps with clk_en landing on a step, then a mid-block restart.
    applyStimulus(30, 130, 100, 0, 1'b1);
    applyStimulus(250, 5, 100, 4, 1'b1);
    applyStimulus(60, 61, 100, 0, 1'b1);

    // Random blocks, spacings and aborts.
    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(1, 3)), ab, 1'($urandom_range(0, 1)));
    end

    // Idle tail: nothing more may change and every expected block was seen.
    clk_en_10x = 1'b1;
    repeat (5) tick();
    checkAll("tail");
    checkOutput("pending_blocks", expEnd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
